// File: rtl/g_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : g_arb_rr
// Description : Round-robin arbiter with a one-hot registered grant. A grant
//               is held while its owner keeps requesting, a one-cycle TURN
//               state enforces an idle gap between owners, and an optional
//               hold limit forces release.
// Ports       : CK   - clock, rising edge
//               RN   - asynchronous active-low reset
//               EN   - arbitration enable (gates new grants only)
//               REQ  - level-sensitive request vector, bit i = requester i
//               GNT  - one-hot registered grant, zero when idle
//               GID  - index of current (or last) owner, 3 bits
//               BUSY - high while any GNT bit is high
//               TOUT - one-cycle pulse on hold-limit force release
// Config      : `define G_ARB_RR_TIMEOUT_EN to build the hold-limit counter;
//               otherwise TOUT is tied low and grants are unbounded.
// Revision    : 1.0 - initial release
// ============================================================================
module g_arb_rr #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            EN,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] GNT,
    output logic [2:0]      GID,
    output logic            BUSY,
    output logic            TOUT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // Elaboration-time guard on the legal parameter ranges.
    generate
        if (NREQ < 2 || NREQ > 8 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_param_chk
            $error("g_arb_rr: NREQ must be 2..8 and HOLD_MAX 2..255");
        end
    endgenerate

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt,   w_gnt_nxt;
    logic [2:0]      r_gid,   w_gid_nxt;
    logic            r_busy,  w_busy_nxt;
    logic [2:0]      r_ptr,   w_ptr_nxt;
    logic [2:0]      w_win;
    logic [2:0]      w_win_inc;
    logic            w_any_req;
    logic            w_own_req;
    logic [NREQ-1:0] w_win_onehot;

`ifdef G_ARB_RR_TIMEOUT_EN
    localparam logic [7:0] c_hold_last = 8'(HOLD_MAX - 1);
    logic [7:0]      r_cnt,  w_cnt_nxt;
    logic            r_tout, w_tout_nxt;
`endif

    assign w_any_req    = |REQ;
    // The owner's request bit, selected through the one-hot grant itself.
    assign w_own_req    = |(REQ & r_gnt);
    assign w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_win_inc    = (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;

    // Winner search: the set bit with the smallest circular distance from
    // the pointer, measured modulo NREQ.
    always_comb begin : p_search
        int v_best;
        int v_dist;
        v_best = NREQ;
        v_dist = 0;
        w_win  = 3'd0;
        for (int j = 0; j < NREQ; j++) begin
            v_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr))
                                        : (j + NREQ - int'(r_ptr));
            if (REQ[j] && (v_dist < v_best)) begin
                v_best = v_dist;
                w_win  = 3'(j);
            end
        end
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gid_nxt   = r_gid;
        w_busy_nxt  = r_busy;
        w_ptr_nxt   = r_ptr;
`ifdef G_ARB_RR_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_tout_nxt  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (EN && w_any_req) begin
                    w_state_nxt = ST_OWN;
                    w_gnt_nxt   = w_win_onehot;
                    w_gid_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_ptr_nxt   = w_win_inc;
`ifdef G_ARB_RR_TIMEOUT_EN
                    w_cnt_nxt   = 8'd0;
`endif
                end
            end
            ST_OWN: begin
`ifdef G_ARB_RR_TIMEOUT_EN
                w_cnt_nxt = r_cnt + 8'd1;
`endif
                if (!w_own_req) begin
                    w_state_nxt = ST_TURN;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
`ifdef G_ARB_RR_TIMEOUT_EN
                // Counter holds the number of completed OWN cycles, so the
                // HOLD_MAX-th cycle ends when it reads HOLD_MAX-1.
                else if (r_cnt == c_hold_last) begin
                    w_state_nxt = ST_TURN;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_tout_nxt  = 1'b1;
                end
`endif
            end
            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin : p_regs
        if (!RN) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_gid   <= 3'd0;
            r_busy  <= 1'b0;
            r_ptr   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gid   <= w_gid_nxt;
            r_busy  <= w_busy_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

`ifdef G_ARB_RR_TIMEOUT_EN
    always_ff @(posedge CK or negedge RN) begin : p_timeout_regs
        if (!RN) begin
            r_cnt  <= 8'd0;
            r_tout <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tout <= w_tout_nxt;
        end
    end
    assign TOUT = r_tout;
`else
    assign TOUT = 1'b0;
`endif

    assign GNT  = r_gnt;
    assign GID  = r_gid;
    assign BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_g_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_g_arb_rr
// Description : Self-checking bench for g_arb_rr (NREQ=4, HOLD_MAX=4).
//               Directed table, hand-written corner sequences and a random
//               phase compared against a queue-free behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_g_arb_rr;

    localparam int NREQ     = 4;
    localparam int HOLD_MAX = 4;

    logic            CK;
    logic            RN;
    logic            EN;
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] GNT;
    logic [2:0]      GID;
    logic            BUSY;
    logic            TOUT;

    int tests;
    int failed;

    // Behavioural model state: owner (-1 = nobody), last owner, pointer,
    // gap flag, number of cycles the grant has been high, timeout pulse.
    int m_own, m_last, m_ptr, m_turn, m_held, m_tout;

    typedef struct {
        logic            en;
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] gnt;
        logic [2:0]      gid;
        logic            busy;
    } vec_t;

    vec_t tbl[17];

    g_arb_rr #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) u_dut (
        .CK   (CK),
        .RN   (RN),
        .EN   (EN),
        .REQ  (REQ),
        .GNT  (GNT),
        .GID  (GID),
        .BUSY (BUSY),
        .TOUT (TOUT)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic model_reset();
        m_own = -1; m_last = 0; m_ptr = 0; m_turn = 0; m_held = 0; m_tout = 0;
    endtask

    task automatic model_step();
        int win;
        m_tout = 0;
        if (m_own >= 0) begin
            if (!REQ[m_own]) begin
                m_own = -1; m_turn = 1;
            end
`ifdef G_ARB_RR_TIMEOUT_EN
            else if (m_held == HOLD_MAX) begin
                m_own = -1; m_turn = 1; m_tout = 1;
            end
`endif
            else begin
                m_held++;
            end
        end else if (m_turn != 0) begin
            m_turn = 0;
        end else if (EN && REQ != '0) begin
            win = -1;
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (m_ptr + i) % NREQ;
                if (REQ[c] && win < 0) win = c;
            end
            m_own  = win;
            m_last = win;
            m_ptr  = (win + 1) % NREQ;
            m_held = 1;
        end
    endtask

    // One clock: model advances on the edge, outputs sampled 1 unit later.
    task automatic step();
        @(posedge CK);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [NREQ-1:0] eg,
                         input logic [2:0] eid, input logic eb, input logic et);
        tests++;
        if (GNT !== eg || GID !== eid || BUSY !== eb || TOUT !== et) begin
            failed++;
            $display("FAIL %s @%0t: got gnt=%b gid=%0d busy=%b tout=%b, expected gnt=%b gid=%0d busy=%b tout=%b",
                     name, $time, GNT, GID, BUSY, TOUT, eg, eid, eb, et);
        end
    endtask

    task automatic check_model(input string name);
        logic [NREQ-1:0] eg;
        eg = '0;
        if (m_own >= 0) eg[m_own] = 1'b1;
        check(name, eg, 3'(m_last), (m_own >= 0), (m_tout != 0));
    endtask

    task automatic do_reset();
        RN = 1'b0;
        EN = 1'b0;
        REQ = '0;
        model_reset();
        #20;
        RN = 1'b1;
    endtask

    initial begin : main
        tests  = 0;
        failed = 0;
        // single requester, then pointer wrap, then enable gating
        tbl[0]  = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b1};
        tbl[1]  = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b1};
        tbl[2]  = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b1};
        tbl[3]  = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b1};
        tbl[4]  = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b1};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 3'd2, 1'b0};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 3'd2, 1'b0};
        tbl[7]  = '{1'b1, 4'b0011, 4'b0001, 3'd0, 1'b1};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0};
        tbl[9]  = '{1'b1, 4'b0011, 4'b0000, 3'd0, 1'b0};
        tbl[10] = '{1'b1, 4'b0011, 4'b0010, 3'd1, 1'b1};
        tbl[11] = '{1'b0, 4'b0010, 4'b0010, 3'd1, 1'b1};
        tbl[12] = '{1'b0, 4'b1010, 4'b0010, 3'd1, 1'b1};
        tbl[13] = '{1'b0, 4'b1000, 4'b0000, 3'd1, 1'b0};
        tbl[14] = '{1'b0, 4'b1000, 4'b0000, 3'd1, 1'b0};
        tbl[15] = '{1'b0, 4'b1000, 4'b0000, 3'd1, 1'b0};
        tbl[16] = '{1'b1, 4'b1000, 4'b1000, 3'd3, 1'b1};

        RN = 1'b0; EN = 1'b0; REQ = '0;
        model_reset();
        #2;
        check("reset_state", 4'b0000, 3'd0, 1'b0, 1'b0);
        @(posedge CK); #1;
        RN = 1'b1;

        for (int i = 0; i < 17; i++) begin
            EN  = tbl[i].en;
            REQ = tbl[i].req;
            step();
            check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].gid, tbl[i].busy, 1'b0);
        end

        // Asynchronous reset between edges while requester 3 owns.
        #3;
        RN = 1'b0;
        #1;
        check("reset_async", 4'b0000, 3'd0, 1'b0, 1'b0);
        model_reset();
        REQ = 4'b1001;
        EN  = 1'b1;
        #1;
        RN = 1'b1;
        step();
        check("reset_first_grant", 4'b0001, 3'd0, 1'b1, 1'b0);

        // Full contention: owners drop after 3 grant cycles, then re-raise.
        do_reset();
        EN  = 1'b1;
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % NREQ;
            for (int c = 0; c < 3; c++) begin
                step();
                check($sformatf("contend_own%0d_c%0d", o, c), 4'(1 << o), 3'(o), 1'b1, 1'b0);
            end
            REQ[o] = 1'b0;
            step();
            check($sformatf("contend_gap1_%0d", k), 4'b0000, 3'(o), 1'b0, 1'b0);
            REQ[o] = 1'b1;
            step();
            check($sformatf("contend_gap2_%0d", k), 4'b0000, 3'(o), 1'b0, 1'b0);
        end

`ifdef G_ARB_RR_TIMEOUT_EN
        do_reset();
        EN  = 1'b1;
        REQ = 4'b0011;
        for (int c = 0; c < HOLD_MAX; c++) begin
            step();
            check($sformatf("tout_hold_c%0d", c), 4'b0001, 3'd0, 1'b1, 1'b0);
        end
        step();
        check("tout_pulse", 4'b0000, 3'd0, 1'b0, 1'b1);
        step();
        check("tout_gap", 4'b0000, 3'd0, 1'b0, 1'b0);
        step();
        check("tout_next_owner", 4'b0010, 3'd1, 1'b1, 1'b0);
`else
        do_reset();
        EN  = 1'b1;
        REQ = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("nolimit_hold_c%0d", c), 4'b0001, 3'd0, 1'b1, 1'b0);
        end
`endif

        // Random phase against the behavioural model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            EN = ($urandom_range(0, 7) != 0);
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 3) == 0) REQ[b] = ~REQ[b];
            end
            step();
            check_model($sformatf("random[%0d]", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/g_arb_rr.md
# g_arb_rr

Round-robin arbiter macro for the schematic-capture macro library. It shares one downstream resource (a bus, a gated buffer or an inverter bank) among up to 8 requesters by issuing a one-hot, registered grant. Each grant is held while its owner keeps requesting. A mandatory idle gap separates successive owners, and an optional hold limit forces release. The macro sits between requesting macros and the shared datapath's select and enable inputs.

## Interface
Parameters:
- NREQ, default 4: number of requesters, legal range 2..8.
- HOLD_MAX, default 16: maximum grant length in cycles, legal range 2..255. Used only when the timeout is compiled in.

Ports:
- CK, input, 1: clock, rising edge.
- RN, input, 1: reset. Asynchronous, active-low.
- EN, input, 1: arbitration enable. Gates new grants only.
- REQ, input, NREQ: request vector. Level-sensitive; bit i belongs to requester i.
- GNT, output, NREQ: one-hot grant, registered. All-zero when no one owns the resource.
- GID, output, 3: index of the current owner, or of the last owner when idle.
- BUSY, output, 1: high while any GNT bit is high. Registered.
- TOUT, output, 1: one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- Reset (RN low) takes effect immediately, with no clock:
  - GNT=0, GID=0, BUSY=0, TOUT=0.
  - Pointer PTR=0, hold counter=0, state IDLE.
- The state machine has three states: IDLE, OWN, TURN.
- **IDLE**
  - If EN=1 and any REQ bit is set: select the first set bit searching upward from PTR, wrapping modulo NREQ.
  - At the next edge: set that GNT bit, set GID and BUSY, load PTR with (winner+1) mod NREQ, clear the counter, go to OWN.
  - Otherwise remain in IDLE with GNT=0.
- **OWN**
  - GNT, GID and BUSY are held. Other requests are ignored.
  - If REQ[GID]=0 at an edge: at that edge clear GNT and BUSY, then go to TURN.
  - The owner is never pre-empted by EN=0 or by other requests.
- **TURN**
  - Lasts exactly one cycle with GNT=0, then goes to IDLE. No arbitration happens in TURN.
- The GID bit width is fixed at 3 regardless of NREQ. Unused upper bits are 0.
- REQ bits at index NREQ and above do not exist. PTR wrap is modulo NREQ, not modulo 8.
- If REQ[GID] drops and rises again while in TURN, that requester competes normally in IDLE, starting from the advanced PTR.

## Timing
- Request-to-grant latency from IDLE: REQ sampled at edge k, GNT high after edge k. This is one registered cycle.
- Release:
  - Owner drops REQ before edge k.
  - GNT is low after edge k.
  - State is TURN during cycle k to k+1, and IDLE after k+1.
  - The earliest next grant is after edge k+2.
  - GNT is therefore low for at least 2 cycles between owners.
- GNT never has more than one bit set. GNT is never nonzero outside OWN.
- When simultaneous requests arrive in IDLE, only PTR order decides the winner.
- Reset mid-grant drops GNT asynchronously. After RN rises, the first grant search starts at index 0.

## Configuration
- Macro: G_ARB_RR_TIMEOUT_EN.
- **Defined:**
  - An 8-bit counter increments on every cycle spent in OWN.
  - If the owner still requests after HOLD_MAX cycles of GNT high:
    - GNT clears at that edge.
    - TOUT is high for exactly that following cycle.
    - The state goes to TURN.
  - PTR already points past the owner, so a continuing owner is served last among the active requesters.
- **Undefined:**
  - No counter is built.
  - TOUT is tied to 0.
  - A grant lasts as long as REQ[GID] stays high.

## Test plan
- **Single requester.** Default parameters. Release reset, EN=1, REQ=0100 for 5 cycles, then 0000.
  - GNT=0100 and GID=2 one cycle after REQ rises, held 5 cycles.
  - GNT=0 after the drop, BUSY tracking GNT.
- **Full contention.** REQ=1111 held. Each owner drops its request after 3 cycles of grant, then re-raises it.
  - Grant order is 0,1,2,3,0.
  - Exactly 2 zero-GNT cycles between owners.
- **Pointer wrap.** PTR=3 (after serving requester 2), REQ=0011.
  - Requester 0 wins, not requester 1. PTR becomes 1.
- **Enable gating.** EN=0 while requester 1 holds GNT, then REQ=1010.
  - Requester 1 keeps GNT until it drops REQ.
  - No new grant until EN=1.
  - Requester 3 is granted 1 cycle after EN rises.
- **Timeout (macro defined), HOLD_MAX=4.** Requester 0 holds REQ high continuously, and requester 1 also requests.
  - GNT=0001 for exactly 4 cycles.
  - TOUT pulses 1 cycle.
  - After the 2-cycle gap, GNT=0010.
- **Reset mid-grant.** Pull RN low between edges while GNT=1000.
  - GNT, BUSY, GID and TOUT are 0 before the next edge.
  - After RN releases, with REQ=1001, requester 0 is granted first.
